turn_clock: RTL and testbench
=============================

TURN_CLOCK -- requirements
Module: turn_clock

Interface
REQ-001 Parameter TOTAL_TIME, default 8'd180, per-player starting clock in seconds (1..255).
REQ-002 Parameter INC_TIME, default 8'd5, seconds added per completed move (used only with TURN_CLOCK_INCREMENT_EN).
REQ-003 clk  input  1  system clock.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 tick  input  1  one-cycle 1 Hz enable strobe, synchronous to clk.
REQ-006 clr  input  1  synchronous game restart from the play controller.
REQ-007 player1_en / player2_en  input  1 each  turn enables from the play controller.
REQ-008 p1_btn / p2_btn  input  1 each  asynchronous raw surrender buttons, active-high.
REQ-009 p1_move_done / p2_move_done  input  1 each  one-cycle move-complete pulses, synchronous.
REQ-010 player1_surrender / player2_surrender  output  1 each  registered surrender flags to the play controller.
REQ-011 p1_time / p2_time  output  8 each  remaining seconds per player.
REQ-012 timeout  output  1  high while either flag was raised by clock expiry rather than a button press.
REQ-013 run_state  output  2  current FSM state encoding (IDLE=0, RUN1=1, RUN2=2, FLAGGED=3).

Function
REQ-014 The FSM SHALL have states IDLE, RUN1, RUN2, FLAGGED, all registered, all outputs registered.
REQ-015 IDLE->RUN1 when player1_en=1 and player2_en=0; IDLE->RUN2 when player2_en=1 and player1_en=0.
REQ-016 RUN1<->RUN2 follow the enables each cycle; both enables equal (00 or 11) SHALL hold the current state with both clocks frozen.
REQ-017 In RUN1, each cycle with tick=1 SHALL decrement p1_time by 1; p2_time unchanged. RUN2 symmetric.
REQ-018 Clocks SHALL saturate at 0, never wrap to 255.
REQ-019 The tick that takes a clock 1->0 SHALL set that player's surrender flag and timeout on the next clock edge; FSM -> FLAGGED.
REQ-020 Buttons SHALL pass a 2-FF synchronizer and rising-edge detector; a detected edge SHALL set that player's flag regardless of turn; latency, pin edge to flag high, is 3 clk cycles.
REQ-021 Surrender flags SHALL be sticky levels held until clr or reset; any flag set -> FLAGGED.
REQ-022 FLAGGED SHALL freeze both clocks and ignore tick, move_done and further flag changes except additional button presses, which also set their flag (both flags may be high).
REQ-023 Expiry and button edge for the same player in one cycle: flag set, timeout=1.
REQ-024 clr=1 SHALL, on the next edge, reload both clocks to TOTAL_TIME, clear flags and timeout, go to IDLE; clr beats tick, move_done and button edges in the same cycle.
REQ-025 move_done pulses outside the owning player's RUN state SHALL be ignored.

Reset
REQ-026 nRST low SHALL asynchronously force: state IDLE, p1_time=p2_time=TOTAL_TIME, both flags 0, timeout 0, synchronizer and edge-detect registers 0.
REQ-027 Reset mid-game SHALL discard all progress; a button held through reset release SHALL NOT register a surrender (edge detector initialised low, sampled input seen as already high after 2 cycles only if it rose after release).

Configuration
REQ-028 With TURN_CLOCK_INCREMENT_EN defined, p1_move_done in RUN1 SHALL add INC_TIME to p1_time on the next edge, saturating at 255 (RUN2/p2 symmetric); tick in the same cycle applies first (time-1+INC_TIME), but a clock already at 0 is not revived.
REQ-029 Without TURN_CLOCK_INCREMENT_EN, move_done inputs SHALL be unused and clocks only count down.

Verification
REQ-030 Reset, player1_en=1, 3 ticks -> run_state=1, p1_time=177, p2_time=180, flags 0.
REQ-031 TOTAL_TIME=2, player2_en=1, 2 ticks -> p2_time=0, player2_surrender=1, timeout=1, run_state=3; further ticks leave p1_time=2.
REQ-032 p1_btn pulsed high for 4 cycles during RUN2 -> player1_surrender=1 exactly 3 cycles after rising edge, timeout=0, held until clr; clr -> both clocks 180, IDLE.
REQ-033 player1_en=player2_en=1 with 5 ticks -> both clocks unchanged, state held.
REQ-034 With TURN_CLOCK_INCREMENT_EN, p1_time=253, p1_move_done and tick same cycle in RUN1 -> p1_time=255 (252+5 saturated); without macro -> 252.
REQ-035 clr, tick and p2_btn edge in same cycle during RUN2 -> IDLE, clocks reloaded, player2_surrender=0.

Source files
------------

// File: rtl/turn_clock_if.sv
// Bus between the play controller and the turn clock. The controller side
// (master) drives turn control, ticks and buttons and reads back the
// surrender flags, the remaining times and the FSM state. The turn clock
// uses the slave side.
interface turn_clock_if;
  // Controller -> turn clock
  logic       tick;
  logic       clr;
  logic       player1_en;
  logic       player2_en;
  logic       p1_btn;
  logic       p2_btn;
  logic       p1_move_done;
  logic       p2_move_done;
  // Turn clock -> controller
  logic       player1_surrender;
  logic       player2_surrender;
  logic [7:0] p1_time;
  logic [7:0] p2_time;
  logic       timeout;
  logic [1:0] run_state;

  modport master (
    output tick, clr, player1_en, player2_en, p1_btn, p2_btn,
           p1_move_done, p2_move_done,
    input  player1_surrender, player2_surrender, p1_time, p2_time,
           timeout, run_state
  );

  modport slave (
    input  tick, clr, player1_en, player2_en, p1_btn, p2_btn,
           p1_move_done, p2_move_done,
    output player1_surrender, player2_surrender, p1_time, p2_time,
           timeout, run_state
  );
endinterface

// File: rtl/turn_clock.sv
// Two-player game clock. Each player owns a seconds counter that runs down
// on the 1 Hz tick while it is that player's turn. A player loses by running
// out of time (timeout) or by pressing the surrender button. Once a flag is
// raised, the clock freezes in FLAGGED until the controller restarts the game.
//
// Optional feature: define TURN_CLOCK_INCREMENT_EN to add INC_TIME seconds to
// a player's clock on every completed move (Fischer increment). In the
// default build the move_done inputs are unused.
module turn_clock #(
  parameter logic [7:0] TOTAL_TIME = 8'd180,
  parameter logic [7:0] INC_TIME   = 8'd5
) (
  input  logic       clk,
  input  logic       nRST,
  turn_clock_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN1    = 2'd1;
  localparam logic [1:0] RUN2    = 2'd2;
  localparam logic [1:0] FLAGGED = 2'd3;

  // Game state
  logic [1:0] state_q, state_d;
  logic [7:0] p1_time_q, p1_time_d;
  logic [7:0] p2_time_q, p2_time_d;
  logic       p1_flag_q, p1_flag_d;
  logic       p2_flag_q, p2_flag_d;
  logic       timeout_q, timeout_d;

  // Button conditioning: two-stage synchronizer, previous-sample register for
  // the rising-edge detector, and a post-reset settle counter.
  logic [1:0] p1_sync_q, p1_sync_d;
  logic [1:0] p2_sync_q, p2_sync_d;
  logic       p1_prev_q, p1_prev_d;
  logic       p2_prev_q, p2_prev_d;
  logic [1:0] settle_q, settle_d;

  logic       armed;
  logic       p1_edge;
  logic       p2_edge;
  logic       en_differ;
  logic       run_active;
  logic       p1_dec;
  logic       p2_dec;
  logic       p1_expire;
  logic       p2_expire;

  // The edge detector is armed only once the synchronizer and the previous
  // sample both hold real pin values. A button already held when reset is
  // released then looks "high all along" instead of producing an edge.
  assign armed   = (settle_q == 2'd3);
  assign p1_edge = armed & p1_sync_q[1] & ~p1_prev_q;
  assign p2_edge = armed & p2_sync_q[1] & ~p2_prev_q;

  // Clocks run only in a RUN state with exactly one turn enable asserted;
  // equal enables freeze both clocks.
  assign en_differ  = bus.player1_en ^ bus.player2_en;
  assign run_active = ((state_q == RUN1) || (state_q == RUN2)) && en_differ;
  assign p1_dec     = run_active && (state_q == RUN1) && bus.tick;
  assign p2_dec     = run_active && (state_q == RUN2) && bus.tick;
  assign p1_expire  = p1_dec && (p1_time_q == 8'd1);
  assign p2_expire  = p2_dec && (p2_time_q == 8'd1);

`ifdef TURN_CLOCK_INCREMENT_EN
  logic p1_add;
  logic p2_add;

  // A completed move only counts for the player whose turn it is.
  assign p1_add = (state_q == RUN1) && bus.p1_move_done;
  assign p2_add = (state_q == RUN2) && bus.p2_move_done;

  // Add the increment, saturating at 255 seconds.
  function automatic logic [7:0] add_increment(input logic [7:0] t);
    logic [8:0] sum;
    sum = {1'b0, t} + {1'b0, INC_TIME};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction
`else
  // Increment disabled: the move-complete pulses and INC_TIME are not used.
  logic unused_move_done;
  assign unused_move_done = ^{INC_TIME, bus.p1_move_done, bus.p2_move_done};
`endif

  // Synchronizer shift, edge-detect history and reset settle counter.
  always_comb begin
    p1_sync_d = {p1_sync_q[0], bus.p1_btn};
    p2_sync_d = {p2_sync_q[0], bus.p2_btn};
    p1_prev_d = p1_sync_q[1];
    p2_prev_d = p2_sync_q[1];
    settle_d  = armed ? settle_q : settle_q + 2'd1;
  end

  // Next game state: restart, countdown, increment, flags and FSM moves.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned; a missing default here would infer a latch.
    state_d   = state_q;
    p1_time_d = p1_time_q;
    p2_time_d = p2_time_q;
    p1_flag_d = p1_flag_q;
    p2_flag_d = p2_flag_q;
    timeout_d = timeout_q;

    if (bus.clr) begin
      // Restart beats every other event in the same cycle.
      state_d   = IDLE;
      p1_time_d = TOTAL_TIME;
      p2_time_d = TOTAL_TIME;
      p1_flag_d = 1'b0;
      p2_flag_d = 1'b0;
      timeout_d = 1'b0;
    end else begin
      // Countdown, saturating at zero.
      if (p1_dec && (p1_time_q != 8'd0)) p1_time_d = p1_time_q - 8'd1;
      if (p2_dec && (p2_time_q != 8'd0)) p2_time_d = p2_time_q - 8'd1;

`ifdef TURN_CLOCK_INCREMENT_EN
      // Increment applies after the tick; a clock at zero stays at zero.
      if (p1_add && (p1_time_d != 8'd0)) p1_time_d = add_increment(p1_time_d);
      if (p2_add && (p2_time_d != 8'd0)) p2_time_d = add_increment(p2_time_d);
`endif

      // Flags are sticky; buttons count in every state, expiry only while
      // that player's clock is running.
      p1_flag_d = p1_flag_q | p1_edge | p1_expire;
      p2_flag_d = p2_flag_q | p2_edge | p2_expire;
      timeout_d = timeout_q | p1_expire | p2_expire;

      case (state_q)
        IDLE, RUN1, RUN2: begin
          if (bus.player1_en && !bus.player2_en)      state_d = RUN1;
          else if (bus.player2_en && !bus.player1_en) state_d = RUN2;
          else                                        state_d = state_q;
        end
        default: state_d = FLAGGED;
      endcase

      if (p1_flag_d || p2_flag_d) state_d = FLAGGED;
    end
  end

  // Game state registers.
  always_ff @(posedge clk or negedge nRST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!nRST) begin
      state_q   <= IDLE;
      p1_time_q <= TOTAL_TIME;
      p2_time_q <= TOTAL_TIME;
      p1_flag_q <= 1'b0;
      p2_flag_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      p1_time_q <= p1_time_d;
      p2_time_q <= p2_time_d;
      p1_flag_q <= p1_flag_d;
      p2_flag_q <= p2_flag_d;
      timeout_q <= timeout_d;
    end
  end

  // Button synchronizer, edge-detect and settle registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      p1_sync_q <= 2'b00;
      p2_sync_q <= 2'b00;
      p1_prev_q <= 1'b0;
      p2_prev_q <= 1'b0;
      settle_q  <= 2'd0;
    end else begin
      p1_sync_q <= p1_sync_d;
      p2_sync_q <= p2_sync_d;
      p1_prev_q <= p1_prev_d;
      p2_prev_q <= p2_prev_d;
      settle_q  <= settle_d;
    end
  end

  // All outputs come straight from flops.
  assign bus.player1_surrender = p1_flag_q;
  assign bus.player2_surrender = p2_flag_q;
  assign bus.p1_time           = p1_time_q;
  assign bus.p2_time           = p2_time_q;
  assign bus.timeout           = timeout_q;
  assign bus.run_state         = state_q;

endmodule

// File: tb/tb_turn_clock.sv
// Directed bench for turn_clock. Three instances share clock and reset:
// u_a uses the default 180 s budget, u_b a 2 s budget for expiry, and u_c a
// 255 s budget for the increment-saturation case.
module tb_turn_clock;

  logic clk;
  logic nRST;
  int   checks;
  int   errors;

  turn_clock_if a_if ();
  turn_clock_if b_if ();
  turn_clock_if c_if ();

  turn_clock #(.TOTAL_TIME(8'd180), .INC_TIME(8'd5)) u_a (
    .clk (clk), .nRST (nRST), .bus (a_if.slave));
  turn_clock #(.TOTAL_TIME(8'd2), .INC_TIME(8'd5)) u_b (
    .clk (clk), .nRST (nRST), .bus (b_if.slave));
  turn_clock #(.TOTAL_TIME(8'd255), .INC_TIME(8'd5)) u_c (
    .clk (clk), .nRST (nRST), .bus (c_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRST   = 1'b0;
    {a_if.tick, a_if.clr, a_if.player1_en, a_if.player2_en} = '0;
    {a_if.p2_btn, a_if.p1_move_done, a_if.p2_move_done}     = '0;
    {b_if.tick, b_if.clr, b_if.player1_en, b_if.player2_en} = '0;
    {b_if.p1_btn, b_if.p2_btn, b_if.p1_move_done, b_if.p2_move_done} = '0;
    {c_if.tick, c_if.clr, c_if.player1_en, c_if.player2_en} = '0;
    {c_if.p1_btn, c_if.p2_btn, c_if.p1_move_done, c_if.p2_move_done} = '0;
    // Player 1 button held through reset release: must not surrender.
    a_if.p1_btn = 1'b1;

    step(3);
    check("reset_state",   a_if.run_state, 0);
    check("reset_p1_time", a_if.p1_time, 180);
    check("reset_p2_time", a_if.p2_time, 180);
    check("reset_flag1",   a_if.player1_surrender, 0);
    check("reset_flag2",   a_if.player2_surrender, 0);
    check("reset_timeout", a_if.timeout, 0);
    check("reset_b_time",  b_if.p2_time, 2);

    nRST = 1'b1;
    step(6);
    check("held_btn_no_flag",  a_if.player1_surrender, 0);
    check("held_btn_idle",     a_if.run_state, 0);
    a_if.p1_btn = 1'b0;
    step(3);

    // Player 1 turn, three ticks.
    a_if.player1_en = 1'b1;
    step();
    check("run1_entered", a_if.run_state, 1);
    a_if.tick = 1'b1;
    step(3);
    a_if.tick = 1'b0;
    check("run1_p1_time", a_if.p1_time, 177);
    check("run1_p2_time", a_if.p2_time, 180);
    check("run1_state",   a_if.run_state, 1);
    check("run1_flag1",   a_if.player1_surrender, 0);
    check("run1_flag2",   a_if.player2_surrender, 0);

    // Both enables high: everything frozen.
    a_if.player2_en = 1'b1;
    a_if.tick = 1'b1;
    step(5);
    a_if.tick = 1'b0;
    check("both_en_p1_time", a_if.p1_time, 177);
    check("both_en_p2_time", a_if.p2_time, 180);
    check("both_en_state",   a_if.run_state, 1);

    // Hand the turn to player 2, two ticks.
    a_if.player1_en = 1'b0;
    step();
    check("run2_entered", a_if.run_state, 2);
    a_if.tick = 1'b1;
    step(2);
    a_if.tick = 1'b0;
    check("run2_p2_time", a_if.p2_time, 178);
    check("run2_p1_time", a_if.p1_time, 177);

    // Player 1 surrenders during player 2's turn: flag 3 cycles after edge.
    a_if.p1_btn = 1'b1;
    step();
    check("btn_lat1_flag", a_if.player1_surrender, 0);
    step();
    check("btn_lat2_flag", a_if.player1_surrender, 0);
    step();
    check("btn_lat3_flag",    a_if.player1_surrender, 1);
    check("btn_lat3_timeout", a_if.timeout, 0);
    check("btn_lat3_state",   a_if.run_state, 3);
    step();
    a_if.p1_btn = 1'b0;
    a_if.tick = 1'b1;
    step(3);
    a_if.tick = 1'b0;
    check("flagged_p2_frozen", a_if.p2_time, 178);
    check("flagged_flag1_held", a_if.player1_surrender, 1);
    check("flagged_flag2_low",  a_if.player2_surrender, 0);

    // Restart.
    a_if.clr = 1'b1;
    step();
    a_if.clr = 1'b0;
    check("clr_p1_time", a_if.p1_time, 180);
    check("clr_p2_time", a_if.p2_time, 180);
    check("clr_state",   a_if.run_state, 0);
    check("clr_flag1",   a_if.player1_surrender, 0);
    check("clr_timeout", a_if.timeout, 0);

    // clr, tick and a player 2 button edge all in one cycle during RUN2.
    step();
    check("pre_race_state", a_if.run_state, 2);
    a_if.p2_btn = 1'b1;
    step(2);
    a_if.clr  = 1'b1;
    a_if.tick = 1'b1;
    step();
    a_if.clr  = 1'b0;
    a_if.tick = 1'b0;
    check("race_state",   a_if.run_state, 0);
    check("race_p2_time", a_if.p2_time, 180);
    check("race_p1_time", a_if.p1_time, 180);
    check("race_flag2",   a_if.player2_surrender, 0);
    step(2);
    check("race_flag2_later", a_if.player2_surrender, 0);
    a_if.p2_btn     = 1'b0;
    a_if.player2_en = 1'b0;

    // Expiry with a 2 s budget on player 2.
    b_if.player2_en = 1'b1;
    step();
    check("b_run2", b_if.run_state, 2);
    b_if.tick = 1'b1;
    step();
    check("b_p2_one",   b_if.p2_time, 1);
    check("b_flag_pre", b_if.player2_surrender, 0);
    step();
    b_if.tick = 1'b0;
    check("b_p2_zero",    b_if.p2_time, 0);
    check("b_flag2",      b_if.player2_surrender, 1);
    check("b_timeout",    b_if.timeout, 1);
    check("b_flagged",    b_if.run_state, 3);
    check("b_flag1_low",  b_if.player1_surrender, 0);
    b_if.player1_en = 1'b1;
    b_if.player2_en = 1'b0;
    b_if.tick = 1'b1;
    step(3);
    b_if.tick = 1'b0;
    check("b_p1_frozen", b_if.p1_time, 2);
    check("b_p2_sat",    b_if.p2_time, 0);
    check("b_still_flagged", b_if.run_state, 3);

    // Tick plus move_done in the same cycle at 253 s.
    c_if.player1_en = 1'b1;
    step();
    c_if.tick = 1'b1;
    step(2);
    check("c_p1_253", c_if.p1_time, 253);
    c_if.p1_move_done = 1'b1;
    step();
    c_if.tick = 1'b0;
    c_if.p1_move_done = 1'b0;
`ifdef TURN_CLOCK_INCREMENT_EN
    check("c_tick_plus_inc", c_if.p1_time, 255);
`else
    check("c_tick_plus_inc", c_if.p1_time, 252);
`endif
    check("c_p2_untouched", c_if.p2_time, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
